// File: rtl/debounce_pkg.sv
// Shared defaults and width helper for the debounce block and its tick generator.
package debounce_pkg;

   localparam int CLK_HZ       = 100_000_000;
   localparam int SAMPLE_HZ    = 1_000;
   localparam int STABLE_TICKS = 8;

   // Bits needed to hold the values 0..n-1, never less than one.
   function automatic int width_of(input int n);
      return (n <= 2) ? 1 : $clog2(n);
   endfunction

endpackage

// File: rtl/debounce_tick_gen.sv
// Free-running divider producing a one-cycle enable every DIV system clocks.
module debounce_tick_gen
   import debounce_pkg::*;
#(
   parameter int DIV = 10
) (
   input  logic clk,
   input  logic reset,
   output logic tick
);

   localparam int W = width_of(DIV);
   localparam logic [W-1:0] CNT_LAST = W'(DIV - 1);
   localparam logic [W-1:0] CNT_PRE  = W'(DIV - 2);

   generate
      if (DIV < 2) begin : g_bad_div
         $error("debounce_tick_gen: DIV must be at least 2");
      end
   endgenerate

   logic [W-1:0] r_cnt;
   logic         r_tick;

   // tick is registered one count early so it is high exactly while r_cnt == DIV-1.
   always_ff @(posedge clk) begin
      if (reset) begin
         r_cnt  <= '0;
         r_tick <= 1'b0;
      end else begin
         r_cnt  <= (r_cnt == CNT_LAST) ? '0 : r_cnt + 1'b1;
         r_tick <= (r_cnt == CNT_PRE);
      end
   end

   assign tick = r_tick;

endmodule

// File: rtl/debounce_multi.sv
// Multi-channel key debouncer: 2-flop synchroniser, tick-qualified stability counter,
// clean level plus registered press/release pulses per channel.
module debounce_multi #(
   parameter int N_CH         = 4,
   parameter int CLK_HZ       = debounce_pkg::CLK_HZ,
   parameter int SAMPLE_HZ    = debounce_pkg::SAMPLE_HZ,
   parameter int STABLE_TICKS = debounce_pkg::STABLE_TICKS,
   parameter bit ACTIVE_LOW   = 1'b0
) (
   input  logic            clk,
   input  logic            reset,
   input  logic [N_CH-1:0] in,
   output logic [N_CH-1:0] key_level,
   output logic [N_CH-1:0] key_press,
   output logic [N_CH-1:0] key_release,
   output logic            any_press
);

   import debounce_pkg::*;

   localparam int DIV = CLK_HZ / SAMPLE_HZ;
   localparam int CW  = width_of(STABLE_TICKS + 1);
   localparam logic [CW-1:0] CNT_LAST = CW'(STABLE_TICKS - 1);

   generate
      if (N_CH < 1) begin : g_bad_nch
         $error("debounce_multi: N_CH must be at least 1");
      end
      if (STABLE_TICKS < 1) begin : g_bad_stable
         $error("debounce_multi: STABLE_TICKS must be at least 1");
      end
   endgenerate

   logic w_tick;

   debounce_tick_gen #(
      .DIV (DIV)
   ) u_tick_gen (
      .clk   (clk),
      .reset (reset),
      .tick  (w_tick)
   );

   logic [N_CH-1:0] w_in_pol;
   logic [N_CH-1:0] w_toggle;
   logic [CW-1:0]   w_cnt_next [N_CH];

   logic [N_CH-1:0] r_sync1;
   logic [N_CH-1:0] r_sync2;
   logic [N_CH-1:0] r_level;
   logic [N_CH-1:0] r_press;
   logic [N_CH-1:0] r_release;
   logic            r_any;
   logic [CW-1:0]   r_cnt [N_CH];

   assign w_in_pol = in ^ {N_CH{ACTIVE_LOW}};

   genvar gi;
   generate
      for (gi = 0; gi < N_CH; gi++) begin : g_ch
         logic w_diff;

         assign w_diff       = r_sync2[gi] ^ r_level[gi];
         assign w_toggle[gi] = w_diff & w_tick & (r_cnt[gi] == CNT_LAST);

         // Agreement clears at once so any bounce restarts qualification.
         always_comb begin
            w_cnt_next[gi] = r_cnt[gi];
            if (!w_diff)
               w_cnt_next[gi] = '0;
            else if (w_tick)
               w_cnt_next[gi] = (r_cnt[gi] == CNT_LAST) ? '0 : r_cnt[gi] + 1'b1;
         end
      end
   endgenerate

   always_ff @(posedge clk) begin
      if (reset) begin
         r_sync1   <= '0;
         r_sync2   <= '0;
         r_level   <= '0;
         r_press   <= '0;
         r_release <= '0;
         r_any     <= 1'b0;
         for (int i = 0; i < N_CH; i++)
            r_cnt[i] <= '0;
      end else begin
         r_sync1   <= w_in_pol;
         r_sync2   <= r_sync1;
         r_level   <= r_level ^ w_toggle;
         r_press   <= w_toggle & ~r_level;
         r_release <= w_toggle & r_level;
         r_any     <= |(w_toggle & ~r_level);
         r_cnt     <= w_cnt_next;
      end
   end

   assign key_level   = r_level;
   assign key_press   = r_press;
   assign key_release = r_release;
   assign any_press   = r_any;

endmodule

// File: tb/tb_debounce_multi.sv
// Directed bench for debounce_multi: DIV=10, STABLE_TICKS=3, one active-high and one active-low instance.
module tb_debounce_multi;

   logic       clk = 1'b0;
   logic       reset = 1'b1;
   logic [3:0] in_a = 4'h0;
   logic [3:0] in_b = 4'hF;

   logic [3:0] level_a, press_a, rel_a;
   logic       any_a;
   logic [3:0] level_b, press_b, rel_b;
   logic       any_b;

   int n_vec = 0;
   int n_err = 0;
   int cyc   = 0;

   debounce_multi #(
      .N_CH(4), .CLK_HZ(1000), .SAMPLE_HZ(100), .STABLE_TICKS(3), .ACTIVE_LOW(1'b0)
   ) u_dut_a (
      .clk(clk), .reset(reset), .in(in_a),
      .key_level(level_a), .key_press(press_a), .key_release(rel_a), .any_press(any_a)
   );

   debounce_multi #(
      .N_CH(4), .CLK_HZ(1000), .SAMPLE_HZ(100), .STABLE_TICKS(3), .ACTIVE_LOW(1'b1)
   ) u_dut_b (
      .clk(clk), .reset(reset), .in(in_b),
      .key_level(level_b), .key_press(press_b), .key_release(rel_b), .any_press(any_b)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   // Pulse bookkeeping, sampled on the falling edge.
   logic       rst_q = 1'b1;
   logic       mon_en = 1'b0;
   logic [3:0] prev_lvl = 4'h0;
   int press_cnt [4] = '{0, 0, 0, 0};
   int rel_cnt   [4] = '{0, 0, 0, 0};
   int press_cyc [4] = '{-1, -1, -1, -1};
   int any_cnt   = 0;
   int bad_cnt   = 0;
   int b_press_cnt = 0;
   int b_press_cyc = -1;

   always @(posedge clk) rst_q <= reset;

   always @(negedge clk) begin
      if (mon_en) begin
         for (int i = 0; i < 4; i++) begin
            if (press_a[i] === 1'b1) begin
               press_cnt[i]++;
               press_cyc[i] = cyc;
            end
            if (rel_a[i] === 1'b1) rel_cnt[i]++;
            if (press_a[i] && rel_a[i]) bad_cnt++;
            if (!rst_q) begin
               if (press_a[i] !== (level_a[i] & ~prev_lvl[i])) bad_cnt++;
               if (rel_a[i] !== (~level_a[i] & prev_lvl[i])) bad_cnt++;
            end
         end
         if (any_a === 1'b1) any_cnt++;
         if (any_a !== |press_a) bad_cnt++;
         if (press_b[1] === 1'b1) begin
            b_press_cnt++;
            b_press_cyc = cyc;
         end
         if (any_b !== |press_b) bad_cnt++;
      end
      prev_lvl = level_a;
   end

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end else begin
         $display("ok   %s: %0d", tag, got);
      end
   endtask

   task automatic step(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   function automatic logic in_window(input int lat);
      return (lat >= 23) && (lat <= 33);
   endfunction

   int t0, p0, p1, p2, p3, r0, r1, r2, a0, rst_cyc;

   initial begin
      // Reset state
      step(3);
      reset = 1'b0;
      chk("rst_level_a", {28'd0, level_a}, 0);
      chk("rst_press_a", {28'd0, press_a}, 0);
      chk("rst_rel_a",   {28'd0, rel_a}, 0);
      chk("rst_any_a",   {31'd0, any_a}, 0);
      mon_en = 1'b1;
      step(40);
      chk("idle_level_a", {28'd0, level_a}, 0);
      chk("idle_level_b_actlow", {28'd0, level_b}, 0);

      // Clean press on channel 0
      p0 = press_cnt[0]; a0 = any_cnt;
      in_a[0] = 1'b1; t0 = cyc;
      step(40);
      chk("clean_press_cnt0", press_cnt[0] - p0, 1);
      chk("clean_any_cnt",    any_cnt - a0, 1);
      chk("clean_latency_ok", {31'd0, in_window(press_cyc[0] - t0)}, 1);
      chk("clean_level",      {28'd0, level_a}, 4'b0001);

      // Bounce on channel 1
      p1 = press_cnt[1];
      for (int k = 0; k < 20; k++) begin
         in_a[1] = ~in_a[1];
         step(3);
      end
      chk("bounce_no_press", press_cnt[1] - p1, 0);
      chk("bounce_level",    {31'd0, level_a[1]}, 0);
      in_a[1] = 1'b1; t0 = cyc;
      step(40);
      chk("bounce_press_cnt", press_cnt[1] - p1, 1);
      chk("bounce_latency_ok", {31'd0, (press_cyc[1] - t0) <= 33}, 1);
      r1 = rel_cnt[1];
      in_a[1] = 1'b0;
      step(40);
      chk("bounce_release_cnt", rel_cnt[1] - r1, 1);
      chk("bounce_level_low",   {31'd0, level_a[1]}, 0);

      // Glitch on channel 2
      p2 = press_cnt[2]; r2 = rel_cnt[2];
      in_a[2] = 1'b1;
      step(15);
      in_a[2] = 1'b0;
      step(40);
      chk("glitch_level", {31'd0, level_a[2]}, 0);
      chk("glitch_pulses", (press_cnt[2] - p2) + (rel_cnt[2] - r2), 0);

      // Simultaneous press on channels 0 and 3
      r0 = rel_cnt[0];
      in_a[0] = 1'b0;
      step(40);
      chk("sim_pre_release0", rel_cnt[0] - r0, 1);
      p0 = press_cnt[0]; p3 = press_cnt[3]; a0 = any_cnt;
      in_a[0] = 1'b1; in_a[3] = 1'b1;
      step(40);
      chk("sim_press_cnt0", press_cnt[0] - p0, 1);
      chk("sim_press_cnt3", press_cnt[3] - p3, 1);
      chk("sim_same_cycle", press_cyc[0] - press_cyc[3], 0);
      chk("sim_any_cnt",    any_cnt - a0, 1);
      chk("sim_level",      {28'd0, level_a}, 4'b1001);

      // Reset mid-operation with keys still held
      r0 = rel_cnt[0]; p0 = press_cnt[0];
      reset = 1'b1;
      step(1);
      reset = 1'b0;
      rst_cyc = cyc;
      chk("midrst_level",   {28'd0, level_a}, 0);
      chk("midrst_press",   {28'd0, press_a}, 0);
      chk("midrst_release", {28'd0, rel_a}, 0);
      chk("midrst_any",     {31'd0, any_a}, 0);
      step(40);
      chk("midrst_no_release", rel_cnt[0] - r0, 0);
      chk("midrst_repress",    press_cnt[0] - p0, 1);
      chk("midrst_repress_latency_ok", {31'd0, (press_cyc[0] - rst_cyc) <= 33}, 1);

      // Active-low instance
      chk("actlow_idle_level", {28'd0, level_b}, 0);
      chk("actlow_no_press_yet", b_press_cnt, 0);
      in_b[1] = 1'b0; t0 = cyc;
      step(40);
      chk("actlow_press_cnt", b_press_cnt, 1);
      chk("actlow_latency_ok", {31'd0, in_window(b_press_cyc - t0)}, 1);
      chk("actlow_level", {28'd0, level_b}, 4'b0010);

      chk("pulse_protocol", bad_cnt, 0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule

// File: doc/debounce_multi.md
# debounce_multi

Parametrised multi-channel key debouncer between raw mechanical switch or keyboard inputs and the synchronous control logic. Each channel is synchronised, then accepted only after it has stayed stable for a programmable number of sample ticks. Each channel outputs a clean level plus single-cycle press and release pulses. Everything runs on the system clock: a one-cycle tick enable replaces any derived clock, so there are no clock-domain crossings beyond the input synchronisers.

## Interface
- `N_CH`, 4: number of independent input channels (≥1).
- `CLK_HZ`, 100_000_000: system clock frequency.
- `SAMPLE_HZ`, 1_000: sample tick rate. `DIV = CLK_HZ/SAMPLE_HZ`; elaboration error if `DIV < 2`.
- `STABLE_TICKS`, 8: consecutive differing ticks required to accept a change (≥1).
- `ACTIVE_LOW`, 0: 1 inverts all raw inputs before synchronisation (pull-up keys).
- `clk`, in, 1: system clock, rising edge.
- `reset`, in, 1: synchronous, active-high reset.
- `in`, in, `N_CH`: raw asynchronous key inputs.
- `key_level`, out, `N_CH`: debounced level per channel, 1 = pressed.
- `key_press`, out, `N_CH`: one-cycle pulse when `key_level[i]` rises.
- `key_release`, out, `N_CH`: one-cycle pulse when `key_level[i]` falls.
- `any_press`, out, 1: OR of `key_press`.

## Operation
- **Tick generator.** Counter `0..DIV-1` with width `$clog2(DIV)`. `tick` is high for exactly one cycle when the counter equals `DIV-1`, and the counter wraps to 0 on that cycle. Period is exactly `DIV` cycles.
- **Per-channel synchroniser.** Two flops on `in[i] ^ ACTIVE_LOW`, giving `s[i]`.
- **Per-channel stability counter.** Width `$clog2(STABLE_TICKS+1)`.
  - `s[i] == key_level[i]`: counter clears on any cycle, tick or not, so a bounce restarts qualification immediately.
  - `s[i] != key_level[i]` with `tick` high and counter `< STABLE_TICKS-1`: counter increments.
  - `s[i] != key_level[i]` with `tick` high and counter `== STABLE_TICKS-1`: `key_level[i]` toggles and the counter clears.
  - Otherwise the counter holds. It never exceeds `STABLE_TICKS-1` and never wraps.
- **Pulses.** `key_press[i]` / `key_release[i]` are registered and high in the first cycle the new `key_level[i]` is visible, for exactly one cycle. Press and release never assert together on one channel.
- **Channel independence.** Channels share only `tick`. Simultaneous events on several channels produce simultaneous pulses.
- **Reset.** All registers clear: tick counter 0, `tick` 0, synchronisers 0 (inactive), stability counters 0, `key_level` 0, `key_press` 0, `key_release` 0, `any_press` 0.
  - Reset mid-operation drops `key_level` to 0 without a release pulse.
  - An input still held after reset is re-qualified from scratch and then produces a fresh press pulse.

## Timing
- Synchroniser latency: 2 cycles.
- Acceptance latency from a stable raw edge to the `key_level` change: between `2 + (STABLE_TICKS-1)·DIV + 1` and `2 + STABLE_TICKS·DIV + 1` cycles, depending on tick phase.
- Any deviation of `s[i]` shorter than `(STABLE_TICKS-1)·DIV` cycles is always rejected.
- Pulses are coincident with the `key_level` edge. `any_press` has the same timing as `key_press`.
- Minimum spacing between opposite-sense accepted edges on one channel is `STABLE_TICKS` ticks.

## Structure
- `debounce_pkg` holds the default constants `CLK_HZ`, `SAMPLE_HZ` and `STABLE_TICKS`, plus a `clog2`-style width helper. It needs no typedefs.
- One sub-module, `debounce_tick_gen` (parameter `DIV`; ports `clk`, `reset`, `tick`). It is reused by other slow-sampling blocks.
- Per-channel logic is a `generate` loop inside `debounce_multi`. It is not a separate module.

## Test plan
All scenarios use `CLK_HZ=1000`, `SAMPLE_HZ=100` (`DIV=10`), `STABLE_TICKS=3`, `N_CH=4`.
- **Clean press.** `in[0]` 0→1 at cycle 0 and held → `key_level[0]` rises once between cycles 23 and 33; `key_press[0]` and `any_press` high for exactly that cycle; other channels stay 0.
- **Bounce.** `in[1]` toggles every 3 cycles for 60 cycles, then holds 1 → no pulse during bouncing; exactly one `key_press[1]` within 33 cycles after the last toggle. A later clean release gives exactly one `key_release[1]`.
- **Glitch rejection.** `in[2]` high for 15 cycles, then low → `key_level[2]` stays 0; no pulses.
- **Simultaneous events.** `in[0]` and `in[3]` rise in the same cycle → `key_press[0]` and `key_press[3]` assert in the same cycle; `any_press` asserts for one cycle.
- **Reset mid-operation.** `key_level[0]=1` and `reset` pulsed for 1 cycle with `in[0]` held high → all outputs 0 the next cycle, no `key_release`. A new `key_press[0]` follows within 33 cycles.
- **`ACTIVE_LOW=1`.** `in` idle at all-ones → `key_level` 0. Driving `in[1]=0` gives a `key_press[1]` with the same latency bounds as the clean-press scenario.
